// File: rtl/iic_slave_link.sv
// iic_slave_link: I2C slave byte link with a fixed 7-bit address.
// SCL and SDA are synchronized into GCLK. START and STOP conditions and
// SCL edges are decoded from the synchronized lines. A byte-level FSM then
// receives write data, drives ACKs and shifts out read data through SDA_OE.
module iic_slave_link #(
    parameter logic [6:0] SLV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       GCLK,
    input  logic       RESET,
    input  logic       SCL,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_FIRST,
    input  logic [7:0] TX_DATA,
    output logic       TX_REQ,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_RX        = 3'd3,
        S_RX_ACK    = 3'd4,
        S_TX        = 3'd5,
        S_TX_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall;
    logic                   start_cond, stop_cond;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] shift_in;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d;
    logic       slot_q, slot_d;         // ninth (ACK) SCL rising edge already seen
    logic       nack_q, nack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_pend_q, rx_pend_d;   // byte landed in RX_DATA, VALID follows
    logic       first_flag_q, first_flag_d;
    logic       first_pend_q, first_pend_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;

    // Synchronize SCL/SDA and decode SCL edges plus START/STOP conditions
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA_IN};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        scl_rise   = scl_s & ~scl_prev_q;
        scl_fall   = ~scl_s & scl_prev_q;
        start_cond = scl_s & sda_prev_q & ~sda_s;
        stop_cond  = scl_s & ~sda_prev_q & sda_s;
    end

    // Byte-level protocol FSM: next state and next registered outputs
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rw_d         = rw_q;
        slot_d       = slot_q;
        nack_d       = nack_q;
        sda_oe_d     = sda_oe_q;
        rx_pend_d    = 1'b0;
        first_flag_d = first_flag_q;
        first_pend_d = first_pend_q;
        rx_valid_d   = rx_pend_q;
        rx_first_d   = rx_pend_q & first_pend_q;
        tx_req_d     = 1'b0;
        busy_d       = busy_q;
        shift_in     = {shift_q[6:0], sda_s};

        // TX_REQ cycle: capture the byte and present its MSB immediately
        if (tx_req_q && (state_q == S_TX)) begin
            shift_d  = TX_DATA;
            sda_oe_d = ~TX_DATA[7];
        end

        case (state_q)
            S_IDLE: begin
                sda_oe_d = 1'b0;
            end

            S_ADDR: begin
                if (scl_rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd8;
                        slot_d    = 1'b0;
                        if (shift_in[7:1] == SLV_ADDR) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = shift_in[0];
                        end else begin
                            state_d  = S_WAIT_STOP;
                            busy_d   = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            // The slave drives the ACK between the falls around the ninth bit
            S_ADDR_ACK, S_RX_ACK: begin
                if (scl_rise) begin
                    slot_d = 1'b1;
                end
                if (scl_fall) begin
                    if (!slot_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        slot_d    = 1'b0;
                        if (state_q == S_RX_ACK) begin
                            state_d = S_RX;
                        end else if (rw_q) begin
                            state_d      = S_TX;
                            tx_req_d     = 1'b1;
                            first_flag_d = 1'b0;
                        end else begin
                            state_d      = S_RX;
                            first_flag_d = 1'b1;
                        end
                    end
                end
            end

            S_RX: begin
                if (scl_rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d    = 4'd8;
                        rx_data_d    = shift_in;
                        rx_pend_d    = 1'b1;
                        first_pend_d = first_flag_q;
                        first_flag_d = 1'b0;
                        slot_d       = 1'b0;
                        state_d      = S_RX_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            S_TX: begin
                if (scl_rise && (bit_cnt_q != 4'd8)) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (scl_fall && (bit_cnt_q != 4'd0)) begin
                    if (bit_cnt_q == 4'd8) begin
                        state_d  = S_TX_ACK;
                        sda_oe_d = 1'b0;
                        slot_d   = 1'b0;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
            end

            S_TX_ACK: begin
                if (scl_rise) begin
                    slot_d = 1'b1;
                    nack_d = sda_s;
                end
                if (scl_fall && slot_q) begin
                    bit_cnt_d = 4'd0;
                    slot_d    = 1'b0;
                    if (!nack_q) begin
                        state_d  = S_TX;
                        tx_req_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_STOP;
                    end
                end
            end

            S_WAIT_STOP: begin
                sda_oe_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus conditions override anything the bit logic decided
        if (start_cond) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            slot_d    = 1'b0;
            sda_oe_d  = 1'b0;
            tx_req_d  = 1'b0;
        end else if (stop_cond) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            slot_d    = 1'b0;
            sda_oe_d  = 1'b0;
            tx_req_d  = 1'b0;
            busy_d    = 1'b0;
        end
    end

    // State registers; reset parks the synchronizers at the idle-bus level
    always_ff @(posedge GCLK) begin
        if (RESET) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rw_q         <= 1'b0;
            slot_q       <= 1'b0;
            nack_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_pend_q    <= 1'b0;
            first_flag_q <= 1'b0;
            first_pend_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rw_q         <= rw_d;
            slot_q       <= slot_d;
            nack_q       <= nack_d;
            sda_oe_q     <= sda_oe_d;
            rx_pend_q    <= rx_pend_d;
            first_flag_q <= first_flag_d;
            first_pend_q <= first_pend_d;
            rx_valid_q   <= rx_valid_d;
            rx_first_q   <= rx_first_d;
            tx_req_q     <= tx_req_d;
            busy_q       <= busy_d;
        end
    end

    assign SDA_OE   = sda_oe_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign RX_FIRST = rx_first_q;
    assign TX_REQ   = tx_req_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_iic_slave_link.sv
// tb_iic_slave_link: drives an I2C master model against iic_slave_link and
// compares ACKs, received bytes, read bytes, TX_REQ counts and BUSY against
// a transaction-level expectation derived from the address and payload.
module tb_iic_slave_link;

    localparam logic [6:0] SLV = 7'h50;
    localparam int         Q   = 4;     // quarter SCL period in GCLK cycles

    logic       clk;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    // Open-drain bus: either side may pull the line low
    assign sda_line = sda_m & ~sda_oe;

    iic_slave_link #(.SLV_ADDR(SLV), .SYNC_STAGES(2)) dut (
        .GCLK    (clk),
        .RESET   (rst),
        .SCL     (scl_m),
        .SDA_IN  (sda_line),
        .SDA_OE  (sda_oe),
        .RX_DATA (rx_data),
        .RX_VALID(rx_valid),
        .RX_FIRST(rx_first),
        .TX_DATA (tx_data),
        .TX_REQ  (tx_req),
        .BUSY    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    bit         jit      = 1'b0;
    logic [7:0] wdat [0:7];

    // Monitor: every RX_VALID pulse, TX_REQ pulse and cycle with SDA_OE high
    logic [8:0] rx_got [$];
    int         txreq_cnt = 0;
    int         oe_cnt    = 0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_got.push_back({rx_first, rx_data});
        if (tx_req === 1'b1) txreq_cnt++;
        if (sda_oe === 1'b1) oe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait one quarter period, optionally jittered by one cycle either way
    task automatic wq();
        int n;
        n = Q;
        if (jit) n = Q - 1 + int'($urandom_range(0, 2));
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        wq(); sda_m = 1'b0; wq(); scl_m = 1'b0;
    endtask

    task automatic m_rstart();
        wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0;
    endtask

    task automatic m_stop();
        wq(); sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq(); wq();
    endtask

    task automatic m_bit_w(input logic b);
        wq(); sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0;
    endtask

    task automatic m_bit_r(output logic r);
        wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); r = sda_line; wq(); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit_w(b[i]);
        m_bit_r(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic last);
        for (int i = 7; i >= 0; i--) m_bit_r(d[i]);
        m_bit_w(last);
    endtask

    // Expected receive stream: wdat[0..n-1], first flag only on element 0
    task automatic chk_rx(input int base, input int n_exp);
        chk("rx_count", 32'(rx_got.size() - base), 32'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            if (base + i < rx_got.size()) begin
                chk("rx_data", {24'h0, rx_got[base+i][7:0]}, {24'h0, wdat[i]});
                chk("rx_first", {31'h0, rx_got[base+i][8]}, (i == 0) ? 32'd1 : 32'd0);
            end
        end
    endtask

    task automatic do_write(input logic [6:0] a, input int n);
        logic ack;
        bit   match;
        int   rb, ob;
        match = (a == SLV);
        rb = rx_got.size();
        ob = oe_cnt;
        m_start();
        write_byte({a, 1'b0}, ack);
        chk("waddr_ack", {31'h0, ack}, {31'h0, !match});
        for (int i = 0; i < n; i++) begin
            write_byte(wdat[i], ack);
            chk("wdata_ack", {31'h0, ack}, {31'h0, !match});
        end
        chk("w_busy", {31'h0, busy}, {31'h0, match});
        m_stop();
        chk("w_busy_stop", {31'h0, busy}, 32'd0);
        if (!match) chk("w_oe_unaddr", 32'(oe_cnt - ob), 32'd0);
        chk_rx(rb, match ? n : 0);
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        logic       ack;
        logic [7:0] d;
        bit         match;
        int         rq, ob, rb;
        match = (a == SLV);
        rq = txreq_cnt;
        ob = oe_cnt;
        rb = rx_got.size();
        m_start();
        write_byte({a, 1'b1}, ack);
        chk("raddr_ack", {31'h0, ack}, {31'h0, !match});
        if (match) begin
            for (int i = 0; i < n; i++) begin
                read_byte(d, (i == n - 1));
                chk("rd_byte", {24'h0, d}, {24'h0, tx_data});
            end
        end
        chk("r_busy", {31'h0, busy}, {31'h0, match});
        m_stop();
        chk("r_busy_stop", {31'h0, busy}, 32'd0);
        chk("tx_req_cnt", 32'(txreq_cnt - rq), match ? 32'(n) : 32'd0);
        if (!match) chk("r_oe_unaddr", 32'(oe_cnt - ob), 32'd0);
        chk("r_no_rx", 32'(rx_got.size() - rb), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] ab;
        logic [6:0] a;
        int         rb, rq, n;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", {31'h0, sda_oe}, 32'd0);
        chk("rst_rx_data", {24'h0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
        chk("rst_rx_first", {31'h0, rx_first}, 32'd0);
        chk("rst_tx_req", {31'h0, tx_req}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);

        // Write 0x3C, 0xFF to our address
        wdat[0] = 8'h3C; wdat[1] = 8'hFF;
        do_write(SLV, 2);

        // Foreign address 0x51 (byte 0xA2)
        wdat[0] = 8'h5A;
        do_write(7'h51, 1);

        // Read two bytes of 0x96, ACK then NACK
        tx_data = 8'h96;
        do_read(SLV, 2);

        // Write 0x11, repeated START, read one byte
        rb = rx_got.size();
        rq = txreq_cnt;
        wdat[0] = 8'h11;
        tx_data = 8'h6B;
        m_start();
        write_byte(8'hA0, ack); chk("rs_addr_ack", {31'h0, ack}, 32'd0);
        write_byte(8'h11, ack); chk("rs_data_ack", {31'h0, ack}, 32'd0);
        chk("rs_busy_before", {31'h0, busy}, 32'd1);
        m_rstart();
        chk("rs_busy_after", {31'h0, busy}, 32'd1);
        write_byte(8'hA1, ack); chk("rs_raddr_ack", {31'h0, ack}, 32'd0);
        read_byte(d, 1'b1);
        chk("rs_rd_byte", {24'h0, d}, 32'h6B);
        chk("rs_busy_read", {31'h0, busy}, 32'd1);
        m_stop();
        chk("rs_busy_stop", {31'h0, busy}, 32'd0);
        chk_rx(rb, 1);
        chk("rs_tx_req", 32'(txreq_cnt - rq), 32'd1);

        // RESET during bit 5 of a write aborts it; a fresh write then works
        rb = rx_got.size();
        m_start();
        write_byte(8'hA0, ack); chk("ab_addr_ack", {31'h0, ack}, 32'd0);
        ab = 8'hC3;
        for (int i = 7; i >= 4; i--) m_bit_w(ab[i]);
        wq(); sda_m = ab[3];
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ab_rx_data", {24'h0, rx_data}, 32'd0);
        chk("ab_busy", {31'h0, busy}, 32'd0);
        chk("ab_sda_oe", {31'h0, sda_oe}, 32'd0);
        wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0;
        for (int i = 2; i >= 0; i--) m_bit_w(ab[i]);
        m_bit_r(ack);
        chk("ab_ack", {31'h0, ack}, 32'd1);
        m_stop();
        chk("ab_no_rx", 32'(rx_got.size() - rb), 32'd0);
        wdat[0] = 8'h55;
        do_write(SLV, 1);

        // Same write as the first one with jittered bus timing
        jit = 1'b1;
        wdat[0] = 8'h3C; wdat[1] = 8'hFF;
        do_write(SLV, 2);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            jit = t[0];
            a = ($urandom_range(0, 3) != 0) ? SLV : 7'($urandom_range(0, 127));
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom_range(0, 255));
            tx_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) do_write(a, n);
            else do_read(a, n);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
